// File: rtl/fs_chunk_seq_pkg.sv
// Shared state encodings and elaboration helpers for the chunked subtractor.
package fs_chunk_seq_pkg;

    // 2'd3 is unused and is treated as IDLE by the sequencer.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fs_Nb.sv
// WIDTH-bit full subtractor: SUB = IN0 - IN1 - BORROW_IN, BORROW_OUT flags underflow.
module fs_Nb #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    input  logic             BORROW_IN,
    output logic [WIDTH-1:0] SUB,
    output logic             BORROW_OUT
);

    // A negative difference leaves the extra top bit set, which is exactly the borrow.
    assign {BORROW_OUT, SUB} = {1'b0, IN0} - {1'b0, IN1} - {{WIDTH{1'b0}}, BORROW_IN};

endmodule

// File: rtl/fs_chunk_seq.sv
// Multi-cycle wide subtractor: one fs_Nb slice reused LSB chunk first, borrow carried in a register.
module fs_chunk_seq
    import fs_chunk_seq_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int CHUNKS = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START_VALID,
    output logic                      START_READY,
    input  logic [WIDTH*CHUNKS-1:0]   IN0,
    input  logic [WIDTH*CHUNKS-1:0]   IN1,
    input  logic                      BORROW_IN,
    output logic                      RESULT_VALID,
    input  logic                      RESULT_READY,
    output logic [WIDTH*CHUNKS-1:0]   SUB,
    output logic                      BORROW_OUT,
    output logic                      BUSY
);

    localparam int TW = WIDTH * CHUNKS;
    localparam int CW = clog2_min1(CHUNKS);
    localparam logic [CW-1:0] LAST_CNT = CW'(CHUNKS - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            borrow_q, borrow_d;
    logic [TW-1:0]   op0_q, op0_d;
    logic [TW-1:0]   op1_q, op1_d;
    logic [TW-1:0]   sub_q, sub_d;

    logic [WIDTH-1:0] chunk_in0;
    logic [WIDTH-1:0] chunk_in1;
    logic [WIDTH-1:0] chunk_sub;
    logic             chunk_borrow;

    assign chunk_in0 = op0_q[int'(cnt_q) * WIDTH +: WIDTH];
    assign chunk_in1 = op1_q[int'(cnt_q) * WIDTH +: WIDTH];

    fs_Nb #(.WIDTH(WIDTH)) u_fs (
        .IN0        (chunk_in0),
        .IN1        (chunk_in1),
        .BORROW_IN  (borrow_q),
        .SUB        (chunk_sub),
        .BORROW_OUT (chunk_borrow)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        op0_d    = op0_q;
        op1_d    = op1_q;
        sub_d    = sub_q;
        case (state_q)
            ST_RUN: begin
                sub_d[int'(cnt_q) * WIDTH +: WIDTH] = chunk_sub;
                borrow_d = chunk_borrow;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (RESULT_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // IDLE, and the unused encoding recovers as IDLE.
                state_d = ST_IDLE;
                if (START_VALID) begin
                    op0_d    = IN0;
                    op1_d    = IN1;
                    borrow_d = BORROW_IN;
                    cnt_d    = '0;
                    sub_d    = '0;
                    state_d  = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            sub_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            sub_q    <= sub_d;
        end
        // Operand registers only matter once loaded on an accept, so they carry no reset.
        op0_q <= op0_d;
        op1_q <= op1_d;
    end

    assign START_READY  = (state_q != ST_RUN) && (state_q != ST_DONE);
    assign BUSY         = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign RESULT_VALID = (state_q == ST_DONE);
    assign SUB          = sub_q;
    assign BORROW_OUT   = borrow_q;

endmodule

// File: tb/tb_fs_chunk_seq.sv
// Directed bench for fs_chunk_seq: 8-bit (2x4) instance plus an exhaustive 3-bit (1x3) instance.
module tb_fs_chunk_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sv, sr, rv, rr, bin, bout, busy;
    logic [7:0] in0, in1, sub;

    logic       sv2, sr2, rv2, rr2, bin2, bout2, busy2;
    logic [2:0] a2, b2, sub2;

    int checks = 0;
    int passes = 0;

    fs_chunk_seq #(.WIDTH(2), .CHUNKS(4)) dut (
        .CLK          (clk),
        .RST          (rst),
        .START_VALID  (sv),
        .START_READY  (sr),
        .IN0          (in0),
        .IN1          (in1),
        .BORROW_IN    (bin),
        .RESULT_VALID (rv),
        .RESULT_READY (rr),
        .SUB          (sub),
        .BORROW_OUT   (bout),
        .BUSY         (busy)
    );

    fs_chunk_seq #(.WIDTH(1), .CHUNKS(3)) dut2 (
        .CLK          (clk),
        .RST          (rst),
        .START_VALID  (sv2),
        .START_READY  (sr2),
        .IN0          (a2),
        .IN1          (b2),
        .BORROW_IN    (bin2),
        .RESULT_VALID (rv2),
        .RESULT_READY (rr2),
        .SUB          (sub2),
        .BORROW_OUT   (bout2),
        .BUSY         (busy2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!sr && n < 30) begin
            tick;
            n++;
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!rv && lat < 30) begin
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        checks++;
        if ({rv, busy, bout, sr} !== 4'b0001) $display("FAIL reset_ctrl: rv/busy/bout/sr=%b required 0001", {rv, busy, bout, sr});
        else passes++;
        checks++;
        if (sub !== 8'h00) $display("FAIL reset_sub: got %h required 00", sub);
        else passes++;
    endtask

    task automatic test_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                           input logic [7:0] exp_sub, input logic exp_b, input string name);
        int n;
        int lat;
        wait_ready(n);
        sv = 1'b1; in0 = a; in1 = b; bin = bi;
        tick;
        sv = 1'b0; in0 = 8'($urandom); in1 = 8'($urandom); bin = 1'($urandom);
        wait_result(lat);
        checks++;
        if (lat !== 4) $display("FAIL %s_latency: got %0d cycles required 4", name, lat);
        else passes++;
        checks++;
        if ({bout, sub} !== {exp_b, exp_sub}) $display("FAIL %s_result: got borrow=%b sub=%h required borrow=%b sub=%h", name, bout, sub, exp_b, exp_sub);
        else passes++;
        rr = 1'b1;
        tick;
        rr = 1'b0;
        checks++;
        if ({rv, busy, sr} !== 3'b001) $display("FAIL %s_return_idle: rv/busy/sr=%b required 001", name, {rv, busy, sr});
        else passes++;
    endtask

    task automatic test_backpressure;
        int n;
        int lat;
        wait_ready(n);
        sv = 1'b1; in0 = 8'h35; in1 = 8'h12; bin = 1'b0;
        tick;
        in0 = 8'h77; in1 = 8'h11; bin = 1'b0;
        wait_result(lat);
        checks++;
        if (lat !== 4) $display("FAIL bp_latency: got %0d required 4", lat);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({rv, sr, busy, bout, sub} !== {4'b1010, 8'h23})
                $display("FAIL bp_hold%0d: rv/sr/busy/bout=%b sub=%h required 1010 sub=23", i, {rv, sr, busy, bout}, sub);
            else passes++;
            tick;
        end
        rr = 1'b1;
        tick;
        rr = 1'b0;
        checks++;
        if ({rv, sr, sub} !== {2'b01, 8'h23}) $display("FAIL bp_idle: rv/sr=%b sub=%h required 01 sub=23", {rv, sr}, sub);
        else passes++;
        tick;
        sv = 1'b0;
        wait_result(lat);
        checks++;
        if (lat !== 4 || {bout, sub} !== {1'b0, 8'h66})
            $display("FAIL bp_second_op: lat=%0d borrow=%b sub=%h required lat=4 borrow=0 sub=66", lat, bout, sub);
        else passes++;
        rr = 1'b1;
        tick;
        rr = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int n;
        wait_ready(n);
        sv = 1'b1; in0 = 8'h35; in1 = 8'h12; bin = 1'b0;
        tick;
        sv = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({rv, busy, sr, bout, sub} !== {4'b0010, 8'h00})
            $display("FAIL abort_state: rv/busy/sr/bout=%b sub=%h required 0010 sub=00", {rv, busy, sr, bout}, sub);
        else passes++;
        test_op(8'hA0, 8'h0A, 1'b0, 8'h96, 1'b0, "after_abort");
    endtask

    task automatic test_exhaustive_w1c3;
        logic [3:0] expv;
        int n;
        int lat;
        int stall;
        for (int i = 0; i < 128; i++) begin
            n = 0;
            while (!sr2 && n < 30) begin
                tick;
                n++;
            end
            a2 = 3'(i); b2 = 3'(i >> 3); bin2 = 1'(i >> 6);
            expv = {1'b0, a2} - {1'b0, b2} - {3'b000, bin2};
            sv2 = 1'b1;
            tick;
            sv2 = 1'b0; a2 = 3'($urandom); b2 = 3'($urandom); bin2 = 1'($urandom);
            lat = 0;
            while (!rv2 && lat < 30) begin
                tick;
                lat++;
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) tick;
            checks++;
            if (n >= 30 || lat !== 3 || rv2 !== 1'b1 || {bout2, sub2} !== expv)
                $display("FAIL w1c3_op%0d: lat=%0d rv=%b borrow=%b sub=%h required lat=3 rv=1 borrow=%b sub=%h",
                         i, lat, rv2, bout2, sub2, expv[3], expv[2:0]);
            else passes++;
            rr2 = 1'b1;
            tick;
            rr2 = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sv = 1'b0; rr = 1'b0; in0 = '0; in1 = '0; bin = 1'b0;
        sv2 = 1'b0; rr2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
        test_reset;
        test_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, "basic");
        test_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "ripple");
        test_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "bin_zero");
        test_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, "bin_under");
        test_backpressure;
        test_reset_mid_run;
        test_exhaustive_w1c3;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
